// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the alarm clock front-panel controller:
// state codes, BCD limits, edit target/field codes and the hh:mm BCD type.
package alarm_ctrl_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_T_HR     = 4'd1;
  localparam logic [3:0] ST_T_MIN    = 4'd2;
  localparam logic [3:0] ST_A_HR     = 4'd3;
  localparam logic [3:0] ST_A_MIN    = 4'd4;
  localparam logic [3:0] ST_COMMIT_T = 4'd5;
  localparam logic [3:0] ST_COMMIT_A = 4'd6;
  localparam logic [3:0] ST_STOP1    = 4'd7;
  localparam logic [3:0] ST_RESTORE  = 4'd8;
  localparam logic [3:0] ST_SNZ_STOP = 4'd9;
  localparam logic [3:0] ST_SNZ_LOAD = 4'd10;

  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  localparam logic TGT_TIME  = 1'b0;
  localparam logic TGT_ALARM = 1'b1;
  localparam logic FLD_HR    = 1'b0;
  localparam logic FLD_MIN   = 1'b1;

  // Operation select for bcd_hhmm_add
  localparam logic [1:0] ADD_SUM     = 2'd0;
  localparam logic [1:0] ADD_INC_HR  = 2'd1;
  localparam logic [1:0] ADD_INC_MIN = 2'd2;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [2:0] m1;
    logic [3:0] m0;
  } hhmm_t;

endpackage

// File: rtl/bcd_hhmm_add.sv
// Combinational hh:mm BCD arithmetic: add N minutes with hour carry and midnight wrap,
// or increment only the hour or only the minute field with independent wrap.
module bcd_hhmm_add
  import alarm_ctrl_pkg::*;
#(
  parameter int N = 1
) (
  input  hhmm_t      a,
  input  logic [1:0] mode,
  output hhmm_t      y
);

  logic [4:0] hr, hr_n;
  logic [5:0] mn, mn_n;
  logic [6:0] msum;
  logic       carry;

  // Work in binary internally; small constant divides map to tiny lookup logic.
  always_comb begin
    hr    = 5'(a.h1) * 5'd10 + 5'(a.h0);
    mn    = 6'(a.m1) * 6'd10 + 6'(a.m0);
    msum  = 7'(mn) + 7'(N);
    carry = 1'b0;
    hr_n  = hr;
    mn_n  = mn;
    case (mode)
      ADD_INC_HR:  hr_n = (hr >= HR_MAX) ? 5'd0 : hr + 5'd1;
      ADD_INC_MIN: mn_n = (mn >= MIN_MAX) ? 6'd0 : mn + 6'd1;
      default: begin
        if (msum > 7'(MIN_MAX)) begin
          mn_n  = 6'(msum - 7'd60);
          carry = 1'b1;
        end else begin
          mn_n = 6'(msum);
        end
        if (carry) hr_n = (hr >= HR_MAX) ? 5'd0 : hr + 5'd1;
      end
    endcase
    y.h1 = 2'(hr_n / 5'd10);
    y.h0 = 4'(hr_n % 5'd10);
    y.m1 = 3'(mn_n / 6'd10);
    y.m0 = 4'(mn_n % 6'd10);
  end

endmodule

// File: rtl/alarm_ctrl_fsm.sv
// Front-panel controller sequencing the alarm_clock load interface (edit, commit, stop, snooze).
// Define ALARM_CTRL_TIMEOUT_EN to abandon idle edit sessions after EDIT_TIMEOUT cycles.
module alarm_ctrl_fsm
  import alarm_ctrl_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
`ifdef ALARM_CTRL_TIMEOUT_EN
  , parameter int EDIT_TIMEOUT = 30
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_set,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  input  logic       btn_al_tog,
  input  logic       Alarm,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [2:0] M_out1,
  input  logic [3:0] M_out0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [2:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic       editing,
  output logic       edit_tgt,
  output logic       edit_fld,
  output logic       snoozing
);

  localparam int SCW = (MAX_SNOOZE < 2) ? 1 : $clog2(MAX_SNOOZE + 1);
  localparam logic [SCW-1:0] SNZ_LIMIT = SCW'(MAX_SNOOZE);

  logic [3:0]     state, next_state;
  hhmm_t          edit_reg, alarm_reg, load_reg, cur_time, inc_sum, snz_sum;
  logic [SCW-1:0] snooze_cnt;
  logic           in_edit, min_fld, up_act, tog_act, timeout;

  assign cur_time = {H_out1, H_out0, M_out1, M_out0};
  assign in_edit  = state inside {ST_T_HR, ST_T_MIN, ST_A_HR, ST_A_MIN};
  assign min_fld  = (state == ST_T_MIN) || (state == ST_A_MIN);
  assign editing  = in_edit;
  assign edit_tgt = (state == ST_A_HR || state == ST_A_MIN) ? TGT_ALARM : TGT_TIME;
  assign edit_fld = min_fld ? FLD_MIN : FLD_HR;
  assign {H_in1, H_in0, M_in1, M_in0} = load_reg;

  // Raw button priority: a pressed higher button masks all lower ones even if it is ignored.
  assign up_act  = in_edit && btn_up && !(btn_stop || btn_snooze || btn_mode || btn_set);
  assign tog_act = (state == ST_IDLE) && btn_al_tog &&
                   !(btn_stop || btn_snooze || btn_mode || btn_set || btn_up);

  bcd_hhmm_add #(.N(1)) u_inc_add (
    .a    (edit_reg),
    .mode (min_fld ? ADD_INC_MIN : ADD_INC_HR),
    .y    (inc_sum)
  );

  bcd_hhmm_add #(.N(SNOOZE_MIN)) u_snz_add (
    .a    (cur_time),
    .mode (ADD_SUM),
    .y    (snz_sum)
  );

`ifdef ALARM_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(EDIT_TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic          any_btn;

  assign any_btn = btn_mode || btn_up || btn_set || btn_stop || btn_snooze || btn_al_tog;
  assign timeout = in_edit && !any_btn && (idle_cnt == TW'(EDIT_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           idle_cnt <= '0;
    else if (!in_edit || any_btn || timeout) idle_cnt <= '0;
    else                                    idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Transient states ignore all buttons and fall through to their successor.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_T_HR, ST_T_MIN, ST_A_HR, ST_A_MIN: begin
        if (btn_stop) begin
          if (Alarm) next_state = ST_STOP1;
        end else if (btn_snooze) begin
          if (Alarm && state == ST_IDLE)
            next_state = (snooze_cnt == SNZ_LIMIT) ? ST_STOP1 : ST_SNZ_STOP;
        end else if (btn_mode) begin
          case (state)
            ST_IDLE:           next_state = ST_T_HR;
            ST_T_HR, ST_T_MIN: next_state = ST_A_HR;
            default:           next_state = ST_IDLE;
          endcase
        end else if (btn_set) begin
          case (state)
            ST_T_HR:  next_state = ST_T_MIN;
            ST_T_MIN: next_state = ST_COMMIT_T;
            ST_A_HR:  next_state = ST_A_MIN;
            ST_A_MIN: next_state = ST_COMMIT_A;
            default:  next_state = state;
          endcase
        end else if (timeout) begin
          next_state = ST_IDLE;
        end
      end
      ST_STOP1:    next_state = snoozing ? ST_RESTORE : ST_IDLE;
      ST_SNZ_STOP: next_state = ST_SNZ_LOAD;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Strobes and load values are registered on entry to the state that owns them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      LD_time    <= 1'b0;
      LD_alarm   <= 1'b0;
      STOP_al    <= 1'b0;
      AL_ON      <= 1'b1;
      snoozing   <= 1'b0;
      snooze_cnt <= '0;
      load_reg   <= '0;
      edit_reg   <= '0;
      alarm_reg  <= '0;
    end else begin
      state    <= next_state;
      LD_time  <= (next_state == ST_COMMIT_T);
      LD_alarm <= (next_state == ST_COMMIT_A) || (next_state == ST_RESTORE) ||
                  (next_state == ST_SNZ_LOAD);
      STOP_al  <= (next_state == ST_STOP1) || (next_state == ST_SNZ_STOP);
      if (tog_act) AL_ON <= !AL_ON;
      case (next_state)
        ST_COMMIT_T: load_reg <= edit_reg;
        ST_COMMIT_A: begin
          load_reg   <= edit_reg;
          alarm_reg  <= edit_reg;
          snoozing   <= 1'b0;
          snooze_cnt <= '0;
        end
        ST_RESTORE: begin
          load_reg   <= alarm_reg;
          snoozing   <= 1'b0;
          snooze_cnt <= '0;
        end
        ST_SNZ_LOAD: begin
          load_reg   <= snz_sum;
          snoozing   <= 1'b1;
          snooze_cnt <= snooze_cnt + 1'b1;
        end
        default: ;
      endcase
      if (state == ST_IDLE && next_state == ST_T_HR)
        edit_reg <= cur_time;
      else if (next_state == ST_A_HR && (state == ST_T_HR || state == ST_T_MIN))
        edit_reg <= alarm_reg;
      else if (up_act)
        edit_reg <= inc_sum;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl_fsm.sv
// Self-checking bench for alarm_ctrl_fsm: directed scenarios plus a randomized run
// against a minute-of-day reference model with a queue of pending one-cycle actions.
module tb_alarm_ctrl_fsm;

  localparam int SNOOZE_MIN   = 5;
  localparam int MAX_SNOOZE   = 3;
  localparam int EDIT_TIMEOUT = 30;

  localparam logic [5:0] B_NONE = 6'b000000;
  localparam logic [5:0] B_STOP = 6'b100000;
  localparam logic [5:0] B_SNZ  = 6'b010000;
  localparam logic [5:0] B_MODE = 6'b001000;
  localparam logic [5:0] B_SET  = 6'b000100;
  localparam logic [5:0] B_UP   = 6'b000010;
  localparam logic [5:0] B_TOG  = 6'b000001;

  localparam int A_NOP = 0, A_SNZLOAD = 1, A_RESTORE = 2;

  localparam logic [20:0] RESET_VEC = {4'b0000, 1'b1, 3'b000, 13'd0};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_mode, btn_up, btn_set, btn_stop, btn_snooze, btn_al_tog;
  logic       Alarm;
  logic [1:0] H_out1, H_in1;
  logic [3:0] H_out0, H_in0, M_out0, M_in0;
  logic [2:0] M_out1, M_in1;
  logic       LD_time, LD_alarm, STOP_al, AL_ON, editing, edit_tgt, edit_fld, snoozing;

  int checks = 0;
  int errors = 0;
  int cur_min;

  // Reference model: times held as minutes of day
  bit m_edit, m_tgt, m_fld, m_alon, m_snz, e_ldt, e_lda, e_stop;
  int m_emin, m_amin, m_hin, m_scnt, m_idle;
  int act_q[$];

  logic [12:0] hin;
  logic [20:0] dut_vec;
  assign hin     = {H_in1, H_in0, M_in1, M_in0};
  assign dut_vec = {editing, edit_tgt, edit_fld, snoozing, AL_ON, LD_time, LD_alarm, STOP_al, hin};

  always #5 clk = ~clk;

  alarm_ctrl_fsm dut (
    .clk(clk), .reset_n(reset_n),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_set(btn_set),
    .btn_stop(btn_stop), .btn_snooze(btn_snooze), .btn_al_tog(btn_al_tog),
    .Alarm(Alarm),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al), .AL_ON(AL_ON),
    .editing(editing), .edit_tgt(edit_tgt), .edit_fld(edit_fld), .snoozing(snoozing)
  );

  function automatic logic [12:0] to_bcd(input int mod);
    int h, m;
    h = mod / 60;
    m = mod % 60;
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [20:0] exp_vec();
    return {m_edit, m_edit & m_tgt, m_edit & m_fld, m_snz, m_alon, e_ldt, e_lda, e_stop, to_bcd(m_hin)};
  endfunction

  task automatic model_reset();
    m_edit = 0; m_tgt = 0; m_fld = 0; m_alon = 1; m_snz = 0;
    e_ldt = 0; e_lda = 0; e_stop = 0;
    m_emin = 0; m_amin = 0; m_hin = 0; m_scnt = 0; m_idle = 0;
    act_q.delete();
  endtask

  task automatic model_edge(input logic [5:0] b, input bit alarm, input int now);
    int kind;
    e_ldt = 0; e_lda = 0; e_stop = 0;
    if (act_q.size() != 0) begin
      kind = act_q.pop_front();
      if (kind == A_SNZLOAD) begin
        m_hin = (now + SNOOZE_MIN) % 1440; e_lda = 1; m_snz = 1; m_scnt++;
      end else if (kind == A_RESTORE) begin
        m_hin = m_amin; e_lda = 1; m_snz = 0; m_scnt = 0;
      end
      m_idle = 0;
      return;
    end
    if (b[5]) begin
      if (alarm) begin
        m_edit = 0; e_stop = 1;
        if (m_snz) act_q.push_back(A_RESTORE);
        act_q.push_back(A_NOP);
      end
    end else if (b[4]) begin
      if (alarm && !m_edit) begin
        e_stop = 1;
        if (m_scnt >= MAX_SNOOZE) begin
          if (m_snz) act_q.push_back(A_RESTORE);
        end else begin
          act_q.push_back(A_SNZLOAD);
        end
        act_q.push_back(A_NOP);
      end
    end else if (b[3]) begin
      if (!m_edit) begin m_edit = 1; m_tgt = 0; m_fld = 0; m_emin = now; end
      else if (!m_tgt) begin m_tgt = 1; m_fld = 0; m_emin = m_amin; end
      else m_edit = 0;
    end else if (b[2]) begin
      if (m_edit) begin
        if (!m_fld) m_fld = 1;
        else begin
          m_edit = 0; m_hin = m_emin;
          if (m_tgt) begin e_lda = 1; m_amin = m_emin; m_snz = 0; m_scnt = 0; end
          else e_ldt = 1;
          act_q.push_back(A_NOP);
        end
      end
    end else if (b[1]) begin
      if (m_edit) begin
        if (!m_fld) m_emin = ((m_emin / 60 + 1) % 24) * 60 + m_emin % 60;
        else        m_emin = (m_emin / 60) * 60 + (m_emin % 60 + 1) % 60;
      end
    end else if (b[0]) begin
      if (!m_edit) m_alon = !m_alon;
    end
    if (b == B_NONE && m_edit) begin
      m_idle++;
`ifdef ALARM_CTRL_TIMEOUT_EN
      if (m_idle == EDIT_TIMEOUT) begin m_edit = 0; m_idle = 0; end
`endif
    end else begin
      m_idle = 0;
    end
  endtask

  task automatic set_time(input int mod);
    cur_min = mod;
    {H_out1, H_out0, M_out1, M_out0} = to_bcd(mod);
  endtask

  task automatic tick(input logic [5:0] b);
    {btn_stop, btn_snooze, btn_mode, btn_set, btn_up, btn_al_tog} = b;
    @(posedge clk);
    model_edge(b, Alarm, cur_min);
    #1;
    {btn_stop, btn_snooze, btn_mode, btn_set, btn_up, btn_al_tog} = B_NONE;
  endtask

  task automatic ticks(input logic [5:0] b, input int n);
    for (int i = 0; i < n; i++) tick(b);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    {btn_stop, btn_snooze, btn_mode, btn_set, btn_up, btn_al_tog} = B_NONE;
    Alarm = 1'b0;
    set_time(0);
    model_reset();
    #12;
    checks++;
    if (dut_vec !== RESET_VEC) begin errors++; $display("[TB] FAIL reset_in: got %h expected %h", dut_vec, RESET_VEC); end
    @(negedge clk);
    reset_n = 1'b1;
    tick(B_NONE);
    checks++;
    if (dut_vec !== RESET_VEC) begin errors++; $display("[TB] FAIL reset_out: got %h expected %h", dut_vec, RESET_VEC); end
  endtask

  task automatic test_time_edit();
    set_time(5 * 60 + 2);
    tick(B_MODE);
    checks++;
    if ({editing, edit_tgt, edit_fld} !== 3'b100) begin errors++; $display("[TB] FAIL time_enter: got %b expected 100", {editing, edit_tgt, edit_fld}); end
    ticks(B_UP, 2);
    tick(B_SET);
    checks++;
    if ({editing, edit_tgt, edit_fld} !== 3'b101) begin errors++; $display("[TB] FAIL time_fld: got %b expected 101", {editing, edit_tgt, edit_fld}); end
    ticks(B_UP, 3);
    checks++;
    if (LD_time !== 1'b0) begin errors++; $display("[TB] FAIL time_early_ld: got %b expected 0", LD_time); end
    tick(B_SET);
    checks++;
    if ({LD_time, LD_alarm, editing} !== 3'b100) begin errors++; $display("[TB] FAIL time_commit: got %b expected 100", {LD_time, LD_alarm, editing}); end
    checks++;
    if (hin !== to_bcd(7 * 60 + 5)) begin errors++; $display("[TB] FAIL time_value: got %h expected %h", hin, to_bcd(7 * 60 + 5)); end
    tick(B_NONE);
    checks++;
    if ({LD_time, hin} !== {1'b0, to_bcd(7 * 60 + 5)}) begin errors++; $display("[TB] FAIL time_hold: got %h expected %h", {LD_time, hin}, {1'b0, to_bcd(7 * 60 + 5)}); end
  endtask

  // Load the alarm register through the edit path, starting from the current alarm value
  task automatic load_alarm(input int hr_ups, input int min_ups);
    tick(B_MODE);
    tick(B_MODE);
    ticks(B_UP, hr_ups);
    tick(B_SET);
    ticks(B_UP, min_ups);
    tick(B_SET);
  endtask

  task automatic test_wrap();
    load_alarm(23, 59);
    checks++;
    if ({LD_alarm, LD_time, hin} !== {2'b10, to_bcd(23 * 60 + 59)}) begin errors++; $display("[TB] FAIL wrap_setup: got %h expected %h", {LD_alarm, LD_time, hin}, {2'b10, to_bcd(23 * 60 + 59)}); end
    tick(B_NONE);
    tick(B_MODE);
    tick(B_MODE);
    checks++;
    if ({editing, edit_tgt, edit_fld} !== 3'b110) begin errors++; $display("[TB] FAIL wrap_alarm_enter: got %b expected 110", {editing, edit_tgt, edit_fld}); end
    tick(B_UP);
    tick(B_SET);
    tick(B_UP);
    tick(B_SET);
    checks++;
    if ({LD_alarm, LD_time, hin} !== {2'b10, 13'd0}) begin errors++; $display("[TB] FAIL wrap_commit: got %h expected %h", {LD_alarm, LD_time, hin}, {2'b10, 13'd0}); end
    tick(B_NONE);
  endtask

  task automatic test_snooze();
    set_time(6 * 60 + 58);
    load_alarm(6, 58);
    tick(B_NONE);
    Alarm = 1'b1;
    tick(B_SNZ);
    checks++;
    if ({STOP_al, LD_alarm} !== 2'b10) begin errors++; $display("[TB] FAIL snooze_stop: got %b expected 10", {STOP_al, LD_alarm}); end
    tick(B_NONE);
    checks++;
    if ({STOP_al, LD_alarm, snoozing, hin} !== {3'b011, to_bcd(7 * 60 + 3)}) begin errors++; $display("[TB] FAIL snooze_load: got %h expected %h", {STOP_al, LD_alarm, snoozing, hin}, {3'b011, to_bcd(7 * 60 + 3)}); end
    tick(B_NONE);
  endtask

  task automatic test_snooze_limit();
    for (int i = 0; i < MAX_SNOOZE - 1; i++) begin
      tick(B_SNZ);
      ticks(B_NONE, 2);
    end
    tick(B_SNZ);
    checks++;
    if ({STOP_al, LD_alarm} !== 2'b10) begin errors++; $display("[TB] FAIL limit_stop: got %b expected 10", {STOP_al, LD_alarm}); end
    tick(B_NONE);
    checks++;
    if ({LD_alarm, snoozing, hin} !== {2'b10, to_bcd(6 * 60 + 58)}) begin errors++; $display("[TB] FAIL limit_restore: got %h expected %h", {LD_alarm, snoozing, hin}, {2'b10, to_bcd(6 * 60 + 58)}); end
    tick(B_NONE);
    set_time(23 * 60 + 57);
    tick(B_SNZ);
    tick(B_NONE);
    checks++;
    if ({LD_alarm, snoozing, hin} !== {2'b11, to_bcd(2)}) begin errors++; $display("[TB] FAIL midnight: got %h expected %h", {LD_alarm, snoozing, hin}, {2'b11, to_bcd(2)}); end
    tick(B_NONE);
  endtask

  task automatic test_priority();
    tick(B_STOP | B_SNZ);
    checks++;
    if (STOP_al !== 1'b1) begin errors++; $display("[TB] FAIL prio_stop: got %b expected 1", STOP_al); end
    tick(B_NONE);
    checks++;
    if ({LD_alarm, snoozing, hin} !== {2'b10, to_bcd(6 * 60 + 58)}) begin errors++; $display("[TB] FAIL prio_restore: got %h expected %h", {LD_alarm, snoozing, hin}, {2'b10, to_bcd(6 * 60 + 58)}); end
    tick(B_NONE);
    Alarm = 1'b0;
    tick(B_STOP);
    checks++;
    if (STOP_al !== 1'b0) begin errors++; $display("[TB] FAIL stop_no_alarm: got %b expected 0", STOP_al); end
    tick(B_TOG);
    checks++;
    if (AL_ON !== 1'b0) begin errors++; $display("[TB] FAIL tog_idle: got %b expected 0", AL_ON); end
    tick(B_MODE);
    tick(B_TOG);
    checks++;
    if ({AL_ON, editing} !== 2'b01) begin errors++; $display("[TB] FAIL tog_edit: got %b expected 01", {AL_ON, editing}); end
    tick(B_MODE);
    tick(B_MODE);
    checks++;
    if ({editing, LD_alarm, LD_time} !== 3'b000) begin errors++; $display("[TB] FAIL cancel: got %b expected 000", {editing, LD_alarm, LD_time}); end
    tick(B_TOG);
    checks++;
    if (AL_ON !== 1'b1) begin errors++; $display("[TB] FAIL tog_back: got %b expected 1", AL_ON); end
  endtask

  task automatic test_reset_mid_edit();
    tick(B_MODE);
    tick(B_SET);
    tick(B_UP);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== RESET_VEC) begin errors++; $display("[TB] FAIL reset_mid: got %h expected %h", dut_vec, RESET_VEC); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(B_NONE);
      checks++;
      if (dut_vec !== RESET_VEC) begin errors++; $display("[TB] FAIL reset_after %0d: got %h expected %h", i, dut_vec, RESET_VEC); end
    end
  endtask

  task automatic test_timeout();
    tick(B_MODE);
    tick(B_MODE);
`ifdef ALARM_CTRL_TIMEOUT_EN
    ticks(B_NONE, EDIT_TIMEOUT - 1);
    checks++;
    if (editing !== 1'b1) begin errors++; $display("[TB] FAIL timeout_early: got %b expected 1", editing); end
    tick(B_NONE);
    checks++;
    if ({editing, LD_alarm} !== 2'b00) begin errors++; $display("[TB] FAIL timeout_exit: got %b expected 00", {editing, LD_alarm}); end
`else
    ticks(B_NONE, EDIT_TIMEOUT + 10);
    checks++;
    if ({editing, edit_tgt} !== 2'b11) begin errors++; $display("[TB] FAIL no_timeout: got %b expected 11", {editing, edit_tgt}); end
    tick(B_MODE);
`endif
  endtask

  task automatic test_random();
    logic [5:0] b;
    for (int i = 0; i < 600; i++) begin
      b = '0;
      for (int k = 0; k < 6; k++) if ($urandom_range(0, 6) == 0) b[k] = 1'b1;
      Alarm = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) set_time(int'($urandom_range(0, 1439)));
      tick(b);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("[TB] FAIL random cycle %0d btn=%b: got %h expected %h", i, b, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_time_edit();
    test_wrap();
    test_snooze();
    test_snooze_limit();
    test_priority();
    test_reset_mid_edit();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
